// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a single-port data memory between the CPU memory stage and a loader port with bounded starvation
module dmem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_valid,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  logic [WW-1:0] wait_cnt;
  logic cpu_req, force_ld, gnt_ld, gnt_cpu;
  always_comb begin
    cpu_req   = cpu_re | cpu_we;
    force_ld  = ld_valid & (wait_cnt == WW'(MAX_WAIT));
    gnt_ld    = reset & ld_valid & (~cpu_req | force_ld);
    gnt_cpu   = cpu_req & ~gnt_ld;
    ld_ready  = gnt_ld;
    cpu_stall = cpu_req & gnt_ld;
    mem_addr  = gnt_ld ? ld_addr : cpu_addr;
    mem_wdata = gnt_ld ? ld_wdata : cpu_wdata;
    mem_we    = reset & (gnt_ld ? ld_we : cpu_we & gnt_cpu);
    cpu_rdata = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt  <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      stall_cnt <= '0;
    end else begin
      wait_cnt  <= (!ld_valid || gnt_ld) ? '0 : (wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1);
      ld_rvalid <= gnt_ld & ~ld_we;
      if (gnt_ld && !ld_we) ld_rdata <= mem_rdata;
      if (cpu_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed stimulus with a reference model of the arbitration rules and literal spot checks
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic reset, cpu_re, cpu_we, ld_valid, ld_we;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic [31:0] cpu_rdata4, ld_rdata4, mem_addr4, mem_wdata4, mem_rdata4;
  logic [31:0] cpu_rdata0, ld_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic cpu_stall4, ld_ready4, ld_rvalid4, mem_we4;
  logic cpu_stall0, ld_ready0, ld_rvalid0, mem_we0;
  logic [15:0] stall_cnt4, stall_cnt0;
  logic [31:0] mem4 [0:255];
  logic [31:0] mem0 [0:255];
  int checks = 0, failures = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  dmem_port_arbiter #(.MAX_WAIT(4)) u4 (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata4), .cpu_stall(cpu_stall4), .ld_valid(ld_valid),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready4),
    .ld_rvalid(ld_rvalid4), .ld_rdata(ld_rdata4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_we(mem_we4), .mem_rdata(mem_rdata4), .stall_cnt(stall_cnt4));
  dmem_port_arbiter #(.MAX_WAIT(0)) u0 (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0), .cpu_stall(cpu_stall0), .ld_valid(ld_valid),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ld_ready0),
    .ld_rvalid(ld_rvalid0), .ld_rdata(ld_rdata0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_we(mem_we0), .mem_rdata(mem_rdata0), .stall_cnt(stall_cnt0));
  assign mem_rdata4 = mem4[mem_addr4[7:0]];
  assign mem_rdata0 = mem0[mem_addr0[7:0]];
  always @(posedge clk) begin
    if (mem_we4) mem4[mem_addr4[7:0]] <= mem_wdata4;
    if (mem_we0) mem0[mem_addr0[7:0]] <= mem_wdata0;
  end
  // reference model for the MAX_WAIT=4 instance: waited counts cycles the current loader request has gone unserved
  localparam int MW = 4;
  int waited;
  logic [31:0] m_mem [0:255];
  logic m_rvalid;
  logic [31:0] m_rdata;
  int m_stall;
  logic e_gnt, e_stall, e_we, cpu_req;
  logic [31:0] e_addr, e_wdata;
  always_comb begin
    cpu_req = cpu_re | cpu_we;
    e_gnt   = reset && ld_valid && (!cpu_req || waited >= MW);
    e_stall = cpu_req && e_gnt;
    e_we    = reset && (e_gnt ? ld_we : cpu_we);
    e_addr  = e_gnt ? ld_addr : cpu_addr;
    e_wdata = e_gnt ? ld_wdata : cpu_wdata;
  end
  always @(posedge clk) begin
    if (!reset) begin
      waited   <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_stall  <= 0;
    end else begin
      if (e_we) m_mem[e_addr[7:0]] <= e_wdata;
      m_rvalid <= e_gnt && !ld_we;
      if (e_gnt && !ld_we) m_rdata <= m_mem[ld_addr[7:0]];
      waited  <= (!ld_valid || e_gnt) ? 0 : waited + 1;
      m_stall <= (e_stall && m_stall < 65535) ? m_stall + 1 : m_stall;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_on) begin
    chk("mdl_mem_we", 64'(mem_we4), 64'(e_we));
    chk("mdl_ld_ready", 64'(ld_ready4), 64'(e_gnt));
    chk("mdl_cpu_stall", 64'(cpu_stall4), 64'(e_stall));
    chk("mdl_ld_rvalid", 64'(ld_rvalid4), 64'(m_rvalid));
    chk("mdl_ld_rdata", 64'(ld_rdata4), 64'(m_rdata));
    chk("mdl_stall_cnt", 64'(stall_cnt4), 64'(m_stall));
    if (reset) begin
      chk("mdl_mem_addr", 64'(mem_addr4), 64'(e_addr));
      chk("mdl_mem_wdata", 64'(mem_wdata4), 64'(e_wdata));
      chk("mdl_cpu_rdata", 64'(cpu_rdata4), 64'(m_mem[e_addr[7:0]]));
    end
  end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cpu_re = 0; cpu_we = 0; ld_valid = 0; ld_we = 0;
  endtask
  task automatic ld(input logic we, input logic [31:0] a, input logic [31:0] d);
    ld_valid = 1; ld_we = we; ld_addr = a; ld_wdata = d;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem4[i] = '0; mem0[i] = '0; m_mem[i] = '0;
    end
    reset = 0; cpu_addr = 0; cpu_wdata = 0; ld_addr = 0; ld_wdata = 0;
    idle();
    nxt();
    chk_on = 1'b1;
    nxt();
    reset = 1;
    @(negedge clk);
    chk("rst_mem_we", 64'(mem_we4), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready4), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall4), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt4), 64'd0);
    chk("rst_ld_rvalid", 64'(ld_rvalid4), 64'd0);
    nxt();
    cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st_mem_we", 64'(mem_we4), 64'd1);
    chk("st_mem_addr", 64'(mem_addr4), 64'h10);
    nxt();
    cpu_we = 0; cpu_re = 1;
    @(negedge clk);
    chk("ld_cpu_rdata", 64'(cpu_rdata4), 64'hDEADBEEF);
    chk("ld_cpu_stall", 64'(cpu_stall4), 64'd0);
    nxt();
    idle(); ld(0, 32'h10, 0);
    @(negedge clk);
    chk("lrd_ready", 64'(ld_ready4), 64'd1);
    nxt();
    idle();
    @(negedge clk);
    chk("lrd_rvalid", 64'(ld_rvalid4), 64'd1);
    chk("lrd_rdata", 64'(ld_rdata4), 64'hDEADBEEF);
    nxt();
    @(negedge clk);
    chk("lrd_rvalid_drop", 64'(ld_rvalid4), 64'd0);
    nxt();
    cpu_re = 1; cpu_addr = 32'h10; ld(0, 32'h10, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("starve_ready_low", 64'(ld_ready4), 64'd0);
      nxt();
    end
    @(negedge clk);
    chk("starve_ready", 64'(ld_ready4), 64'd1);
    chk("starve_stall", 64'(cpu_stall4), 64'd1);
    nxt();
    ld_valid = 0;
    @(negedge clk);
    chk("starve_cnt", 64'(stall_cnt4), 64'd1);
    chk("starve_wait", 64'(u4.wait_cnt), 64'd0);
    chk("starve_rdata", 64'(ld_rdata4), 64'hDEADBEEF);
    nxt();
    idle(); ld(1, 32'h30, 32'h11111111);
    nxt();
    ld(1, 32'h31, 32'h22222222);
    @(negedge clk);
    chk("b2b_ready", 64'(ld_ready4), 64'd1);
    nxt();
    idle(); cpu_re = 1; cpu_addr = 32'h31;
    @(negedge clk);
    chk("b2b_readback", 64'(cpu_rdata4), 64'h22222222);
    ld(0, 32'h30, 0);
    nxt(); nxt();
    ld_valid = 0;
    nxt();
    ld(0, 32'h30, 0);
    nxt(); nxt();
    @(negedge clk);
    chk("abandon_ready", 64'(ld_ready4), 64'd0);
    nxt(); nxt();
    @(negedge clk);
    chk("abandon_grant", 64'(ld_ready4), 64'd1);
    nxt();
    idle(); cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D; ld(1, 32'h20, 32'h55555555);
    @(negedge clk);
    chk("mw0_mem_we", 64'(mem_we0), 64'd1);
    chk("mw0_mem_addr", 64'(mem_addr0), 64'h20);
    chk("mw0_stall", 64'(cpu_stall0), 64'd1);
    nxt();
    ld_valid = 0;
    @(negedge clk);
    chk("mw0_cpu_we", 64'(mem_we0), 64'd1);
    chk("mw0_cpu_addr", 64'(mem_addr0), 64'h40);
    chk("mw0_cpu_nostall", 64'(cpu_stall0), 64'd0);
    nxt();
    idle(); ld(0, 32'h30, 0);
    @(negedge clk);
    chk("rstx_ready", 64'(ld_ready4), 64'd1);
    nxt();
    ld(1, 32'h50, 32'h1); cpu_we = 1;
    reset = 0;
    @(negedge clk);
    chk("rstx_rvalid", 64'(ld_rvalid4), 64'd1);
    chk("rstx_force_we", 64'(mem_we4), 64'd0);
    chk("rstx_force_ready", 64'(ld_ready4), 64'd0);
    chk("rstx_force_stall", 64'(cpu_stall4), 64'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("rstx_rvalid_clr", 64'(ld_rvalid4), 64'd0);
    chk("rstx_rdata_clr", 64'(ld_rdata4), 64'd0);
    chk("rstx_stall_clr", 64'(stall_cnt4), 64'd0);
    chk("rstx_stall_clr0", 64'(stall_cnt0), 64'd0);
    nxt();
    reset = 1;
    nxt();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
